// File: rtl/hams_chunk_loader.sv
// hams_chunk_loader: packs a valid/ready element stream into PAD_PAIR-padded chunks for
// hams_sortNelem, with credit flow control. Define HAMS_LOADER_CNT_EN to add chunk_total_o.

package hams_pkg;
    localparam int unsigned NUM_ELEMENTS = 8;
    localparam int unsigned KEY_W        = 16;
    localparam int unsigned TAG_W        = 16;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [TAG_W-1:0] tag;
    } pair;
endpackage

module hams_chunk_loader
    import hams_pkg::*;
#(
    parameter pair         PAD_PAIR    = '1,
    parameter int unsigned MAX_CREDITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  pair                     in_pair,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic                    flush_i,
    output pair [NUM_ELEMENTS-1:0]  chunk_o,
    output logic                    chunk_vld_o,
    output logic [$clog2(NUM_ELEMENTS):0] chunk_len_o,
    input  logic                    credit_ret_i,
    output logic                    credit_err_o
`ifdef HAMS_LOADER_CNT_EN
    ,
    output logic [31:0]             chunk_total_o
`endif
);

    localparam int unsigned CW  = $clog2(NUM_ELEMENTS);
    localparam int unsigned LW  = CW + 1;
    localparam int unsigned CRW = $clog2(MAX_CREDITS + 1);

    typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;

    state_t                  state_q, state_next;
    logic [CW-1:0]           cnt_q, cnt_next;
    pair [NUM_ELEMENTS-1:0]  buf_q;
    logic [CRW-1:0]          credits_q, credits_next;
    logic                    flush_pend_q, flush_pend_next;

    logic                    accept;
    logic                    full_hit;
    logic                    has_data;
    logic                    emit;
    logic                    ret_over;
    pair [NUM_ELEMENTS-1:0]  chunk_next;
    logic [LW-1:0]           len_next;

    // Trigger evaluation, next chunk image and credit bookkeeping
    always_comb begin
        accept          = in_valid && in_ready;
        full_hit        = accept && (cnt_q == CW'(NUM_ELEMENTS - 1));
        has_data        = (cnt_q != '0) || accept;
        emit            = (state_q != STALL) &&
                          (full_hit || (accept && in_last) || ((flush_i || flush_pend_q) && has_data));
        ret_over        = credit_ret_i && !emit && (credits_q == CRW'(MAX_CREDITS));
        len_next        = LW'(cnt_q) + LW'(accept);
        chunk_next      = '0;
        credits_next    = credits_q;
        cnt_next        = cnt_q;
        flush_pend_next = (flush_pend_q || (flush_i && (cnt_q != '0))) && !emit;

        for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
            if (LW'(i) < LW'(cnt_q))
                chunk_next[i] = buf_q[i];
            else if (accept && (CW'(i) == cnt_q))
                chunk_next[i] = in_pair;
            else
                chunk_next[i] = PAD_PAIR;
        end

        if (emit && !credit_ret_i)
            credits_next = credits_q - CRW'(1);
        else if (!emit && credit_ret_i && !ret_over)
            credits_next = credits_q + CRW'(1);

        if (emit)
            cnt_next = '0;
        else if (accept)
            cnt_next = cnt_q + CW'(1);

        if (credits_next == '0)
            state_next = STALL;
        else if (cnt_next != '0)
            state_next = FILL;
        else
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            credits_q    <= CRW'(MAX_CREDITS);
            flush_pend_q <= 1'b0;
            in_ready     <= 1'b0;
            chunk_vld_o  <= 1'b0;
            chunk_len_o  <= '0;
            credit_err_o <= 1'b0;
            for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
                buf_q[i]   <= PAD_PAIR;
                chunk_o[i] <= PAD_PAIR;
            end
`ifdef HAMS_LOADER_CNT_EN
            chunk_total_o <= '0;
`endif
        end else begin
            state_q      <= state_next;
            cnt_q        <= cnt_next;
            credits_q    <= credits_next;
            flush_pend_q <= flush_pend_next;
            // Ready tracks the post-update credit count, so it lags credit events by one cycle
            in_ready     <= (credits_next != '0);
            chunk_vld_o  <= emit;
            if (accept)
                buf_q[cnt_q] <= in_pair;
            if (emit) begin
                chunk_o     <= chunk_next;
                chunk_len_o <= len_next;
            end
            if (ret_over)
                credit_err_o <= 1'b1;
`ifdef HAMS_LOADER_CNT_EN
            if (emit)
                chunk_total_o <= chunk_total_o + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_hams_chunk_loader.sv
// Self-checking bench for hams_chunk_loader: directed scenarios plus a randomized phase,
// compared every cycle against a queue-based reference model.

module tb_hams_chunk_loader;
    import hams_pkg::*;

    localparam int unsigned N    = NUM_ELEMENTS;
    localparam int unsigned PW   = $bits(pair);
    localparam int unsigned CHW  = N * PW;
    localparam int unsigned MAXC = 2;
    localparam pair         PAD  = '1;

    logic                    clk;
    logic                    rst_n;
    pair                     in_pair;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic                    flush_i;
    pair [N-1:0]             chunk_o;
    logic                    chunk_vld_o;
    logic [$clog2(N):0]      chunk_len_o;
    logic                    credit_ret_i;
    logic                    credit_err_o;
`ifdef HAMS_LOADER_CNT_EN
    logic [31:0]             chunk_total_o;
`endif

    hams_chunk_loader #(.PAD_PAIR(PAD), .MAX_CREDITS(MAXC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_pair      (in_pair),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .flush_i      (flush_i),
        .chunk_o      (chunk_o),
        .chunk_vld_o  (chunk_vld_o),
        .chunk_len_o  (chunk_len_o),
        .credit_ret_i (credit_ret_i),
        .credit_err_o (credit_err_o)
`ifdef HAMS_LOADER_CNT_EN
        ,
        .chunk_total_o(chunk_total_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending elements as a queue, credits as a plain count
    pair              mq[$];
    int               mcred;
    bit               merr;
    bit               mpend;
    bit               mready;
    logic [CHW-1:0]   exp_chunk;
    int               exp_len;
    bit               last_acc;
    bit               last_emit;
    int               passed;
    int               total;
    int               dut_pulses;

    task automatic chk(input string tag, input logic [CHW-1:0] obs, input logic [CHW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic pair mk(input int k);
        pair p;
        p.key = KEY_W'(k);
        p.tag = TAG_W'($urandom);
        return p;
    endfunction

    task automatic step(input logic v, input pair d, input logic l, input logic f, input logic r);
        bit emit;
        @(negedge clk);
        in_valid     = v;
        in_pair      = d;
        in_last      = l;
        flush_i      = f;
        credit_ret_i = r;
        chk("in_ready", in_ready, mready);
        last_acc = v && mready;
        if (last_acc) mq.push_back(d);
        emit = (mcred > 0) &&
               ((last_acc && (mq.size() == N || l)) || ((f || mpend) && mq.size() > 0));
        if (emit) begin
            for (int i = 0; i < N; i++)
                exp_chunk[i*PW +: PW] = (i < mq.size()) ? mq[i] : PAD;
            exp_len = mq.size();
            mq.delete();
            mpend = 1'b0;
        end else if (f && mq.size() > 0) begin
            mpend = 1'b1;
        end
        if (emit && r) begin
        end else if (emit) begin
            mcred--;
        end else if (r) begin
            if (mcred == MAXC) merr = 1'b1;
            else mcred++;
        end
        mready = (mcred != 0);
        @(posedge clk);
        #1;
        chk("chunk_vld", chunk_vld_o, emit);
        chk("chunk", chunk_o, exp_chunk);
        chk("chunk_len", chunk_len_o, exp_len);
        chk("credit_err", credit_err_o, merr);
        if (chunk_vld_o) dut_pulses++;
        last_emit = emit;
    endtask

    task automatic idle(input logic r);
        step(1'b0, mk(0), 1'b0, 1'b0, r);
    endtask

    task automatic ret_all();
        for (int c = 0; c < 8 && mcred < MAXC; c++) idle(1'b1);
    endtask

    // Hold in_valid and send count elements; optionally return a credit one cycle after each pulse
    task automatic stream(input int count, input int base, input bit ret_after,
                          input int lastpos, input int flushpos);
        int sent = 0;
        bit r = 1'b0;
        for (int cyc = 0; cyc < 4 * count + 8 && sent < count; cyc++) begin
            step(1'b1, mk(base + sent), 1'(sent == lastpos), 1'(sent == flushpos), r);
            r = ret_after && last_emit;
            if (last_acc) sent++;
        end
        chk("stream_done", sent, count);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; flush_i = 1'b0; credit_ret_i = 1'b0;
        #1;
        mq.delete();
        mcred = MAXC; merr = 1'b0; mpend = 1'b0; mready = 1'b0;
        for (int i = 0; i < N; i++) exp_chunk[i*PW +: PW] = PAD;
        exp_len = 0;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_vld", chunk_vld_o, 1'b0);
        chk("rst_chunk", chunk_o, exp_chunk);
        chk("rst_len", chunk_len_o, 0);
        chk("rst_err", credit_err_o, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int p0;
        int sent;
        passed = 0; total = 0; dut_pulses = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_pair = '0; in_last = 1'b0;
        flush_i = 1'b0; credit_ret_i = 1'b0;
        do_reset();

        // Two full back-to-back chunks with prompt credit return
        p0 = dut_pulses;
        stream(16, 0, 1'b1, -1, -1);
        chk("two_pulses", dut_pulses - p0, 2);
        ret_all();

        // Short chunk closed by in_last, then a full chunk whose 8th element has last+flush
        p0 = dut_pulses;
        stream(3, 100, 1'b1, 2, -1);
        chk("last_len3_pulse", dut_pulses - p0, 1);
        ret_all();
        p0 = dut_pulses;
        stream(8, 200, 1'b1, 7, 7);
        chk("coincident_one_pulse", dut_pulses - p0, 1);
        ret_all();

        // Credit exhaustion: 24 elements, no returns until stalled
        p0 = dut_pulses;
        sent = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            step(1'b1, mk(300 + sent), 1'b0, 1'b0, 1'b0);
            if (last_acc) sent++;
        end
        chk("stall_accepted", sent, 16);
        chk("stall_pulses", dut_pulses - p0, 2);
        chk("stall_ready", in_ready, 1'b0);
        step(1'b1, mk(300 + sent), 1'b0, 1'b0, 1'b1);
        stream(8, 316, 1'b0, -1, -1);
        chk("third_chunk", dut_pulses - p0, 3);
        ret_all();

        // Return at full credits sets the sticky error; flush on empty is ignored
        idle(1'b1);
        idle(1'b0);
        p0 = dut_pulses;
        step(1'b0, mk(0), 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        chk("empty_flush", dut_pulses - p0, 0);
        chk("err_sticky", credit_err_o, 1'b1);

        // Reset in the middle of a fill
        stream(5, 400, 1'b0, -1, -1);
        do_reset();
        p0 = dut_pulses;
        idle(1'b0);
        idle(1'b0);
        chk("no_pulse_after_rst", dut_pulses - p0, 0);
        stream(8, 500, 1'b1, -1, -1);
        chk("post_rst_chunk", dut_pulses - p0, 1);
        ret_all();

        // Randomized traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            step(1'($urandom_range(0, 3) != 0), mk(int'($urandom)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
                 1'((mcred < MAXC) && ($urandom_range(0, 2) == 0)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
